pc_sequencer: RTL and testbench

Program-counter controller for the five-stage MIPS pipeline. It owns the PC register and arbitrates every request that can redirect it: sequential fetch, taken branch from EX, J/JAL from ID, and JR/JALR from ID. It also handles load-use stalls, HALT, and start/step control from the debug unit. It sits in IF, drives the instruction-memory address, and produces the flush and advance-enable strobes for the IF/ID and ID/EX pipeline registers.

---
 rtl/pc_seq_pkg.sv | 6 +
 rtl/pc_seq_if.sv | 36 +++
 rtl/pc_target_calc.sv | 24 ++
 rtl/pc_sequencer.sv | 82 ++++++++
 tb/tb_pc_sequencer.sv | 116 +++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state/redirect-source types and constants for pc_sequencer
package pc_seq_pkg;
  localparam int PC_INCR = 4;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED, S_STEP} state_t;
  typedef enum logic [2:0] {SRC_SEQ, SRC_BR, SRC_JR, SRC_J, SRC_HOLD} src_t;
endpackage

// File: rtl/pc_seq_if.sv
// pc_seq_if: debug/hazard/decode requests into the PC sequencer and its fetch/flush outputs
interface pc_seq_if #(
  parameter int N_BITS_DW  = 32,
  parameter int N_BITS_W   = 16,
  parameter int N_BITS_IDX = 26
);
  logic                  i_start;
  logic                  i_step;
  logic                  i_stall;
  logic                  i_halt;
  logic                  i_branch_taken;
  logic [N_BITS_DW-1:0]  i_branch_pc;
  logic [N_BITS_W-1:0]   i_branch_offset;
  logic                  i_jump;
  logic [N_BITS_DW-1:0]  i_jump_pc;
  logic [N_BITS_IDX-1:0] i_instr_index;
  logic                  i_jr;
  logic [N_BITS_DW-1:0]  i_jr_target;
  logic [N_BITS_DW-1:0]  o_pc;
  logic                  o_pc_en;
  logic                  o_flush_if_id;
  logic                  o_flush_id_ex;
  logic                  o_running;
  logic                  o_halted;
  logic                  o_misaligned;
  modport master (
    output i_start, i_step, i_stall, i_halt, i_branch_taken, i_branch_pc, i_branch_offset,
           i_jump, i_jump_pc, i_instr_index, i_jr, i_jr_target,
    input  o_pc, o_pc_en, o_flush_if_id, o_flush_id_ex, o_running, o_halted, o_misaligned
  );
  modport slave (
    input  i_start, i_step, i_stall, i_halt, i_branch_taken, i_branch_pc, i_branch_offset,
           i_jump, i_jump_pc, i_instr_index, i_jr, i_jr_target,
    output o_pc, o_pc_en, o_flush_if_id, o_flush_id_ex, o_running, o_halted, o_misaligned
  );
endinterface

// File: rtl/pc_target_calc.sv
// pc_target_calc: branch, J-type and JR redirect target arithmetic
module pc_target_calc #(
  parameter int N_BITS_DW  = 32,
  parameter int N_BITS_W   = 16,
  parameter int N_BITS_IDX = 26
) (
  input  logic [N_BITS_DW-1:0]  i_branch_pc,
  input  logic [N_BITS_W-1:0]   i_branch_offset,
  input  logic [N_BITS_DW-1:0]  i_jump_pc,
  input  logic [N_BITS_IDX-1:0] i_instr_index,
  input  logic [N_BITS_DW-1:0]  i_jr_target,
  output logic [N_BITS_DW-1:0]  o_br_target,
  output logic [N_BITS_DW-1:0]  o_j_target,
  output logic [N_BITS_DW-1:0]  o_jr_target
);
  logic [N_BITS_DW-1:0] w_offset;
  // word offset is sign-extended then scaled to bytes; jump keeps the top region bits of PC+4
  always_comb begin
    w_offset    = {{(N_BITS_DW-N_BITS_W){i_branch_offset[N_BITS_W-1]}}, i_branch_offset};
    o_br_target = i_branch_pc + (w_offset << 2);
    o_j_target  = {i_jump_pc[N_BITS_DW-1:N_BITS_IDX+2], i_instr_index, 2'b00};
    o_jr_target = {i_jr_target[N_BITS_DW-1:2], 2'b00};
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register, run-control FSM and redirect priority mux (optional PC_STEP_MODE_EN adds single-step)
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                    N_BITS_DW  = 32,
  parameter int                    N_BITS_W   = 16,
  parameter int                    N_BITS_IDX = 26,
  parameter logic [N_BITS_DW-1:0]  PC_RESET   = '0
) (
  input logic     i_clk,
  input logic     i_reset,
  pc_seq_if.slave bus
);
  state_t               r_state;
  state_t               w_state_next;
  state_t               w_go;
  src_t                 w_src;
  logic                 w_active;
  logic [N_BITS_DW-1:0] r_pc;
  logic [N_BITS_DW-1:0] w_pc_next;
  logic [N_BITS_DW-1:0] w_br;
  logic [N_BITS_DW-1:0] w_j;
  logic [N_BITS_DW-1:0] w_jr;
  pc_target_calc #(
    .N_BITS_DW  (N_BITS_DW),
    .N_BITS_W   (N_BITS_W),
    .N_BITS_IDX (N_BITS_IDX)
  ) u_calc (
    .i_branch_pc     (bus.i_branch_pc),
    .i_branch_offset (bus.i_branch_offset),
    .i_jump_pc       (bus.i_jump_pc),
    .i_instr_index   (bus.i_instr_index),
    .i_jr_target     (bus.i_jr_target),
    .o_br_target     (w_br),
    .o_j_target      (w_j),
    .o_jr_target     (w_jr)
  );
`ifdef PC_STEP_MODE_EN
  assign w_go     = S_STEP;
  assign w_active = (r_state == S_RUN) || (r_state == S_STEP && bus.i_step);
`else
  assign w_go     = S_RUN;
  assign w_active = (r_state == S_RUN);
`endif
  // state and PC register; reset overrides any request in the same cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_pc    <= PC_RESET;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end
  // next state: halt only counts when no branch squashes the ID instruction
  always_comb begin
    w_state_next = r_state == S_IDLE ? (bus.i_start ? w_go : S_IDLE) :
                   (w_active && !bus.i_branch_taken && bus.i_halt) ? S_HALTED : r_state;
  end
  // redirect priority: branch > halt > stall > jr > jump > sequential
  always_comb begin
    w_src     = !w_active           ? SRC_HOLD :
                bus.i_branch_taken  ? SRC_BR   :
                (bus.i_halt || bus.i_stall) ? SRC_HOLD :
                bus.i_jr            ? SRC_JR   :
                bus.i_jump          ? SRC_J    : SRC_SEQ;
    w_pc_next = w_src == SRC_BR  ? w_br :
                w_src == SRC_JR  ? w_jr :
                w_src == SRC_J   ? w_j  :
                w_src == SRC_SEQ ? r_pc + N_BITS_DW'(PC_INCR) : r_pc;
  end
  // pipeline strobes from the selected source and status decoded from the state register
  always_comb begin
    bus.o_pc          = r_pc;
    bus.o_pc_en       = w_src != SRC_HOLD;
    bus.o_flush_if_id = w_src == SRC_BR || w_src == SRC_JR || w_src == SRC_J;
    bus.o_flush_id_ex = w_src == SRC_BR;
    bus.o_misaligned  = w_src == SRC_JR && |bus.i_jr_target[1:0];
    bus.o_running     = r_state == S_RUN || r_state == S_STEP;
    bus.o_halted      = r_state == S_HALTED;
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer (default and PC_STEP_MODE_EN builds)
module tb_pc_sequencer;
  logic clk;
  logic rst;
  int n_run = 0;
  int n_fail = 0;
  logic [31:0] q[$];
  pc_seq_if bus ();
  pc_sequencer dut (.i_clk(clk), .i_reset(rst), .bus(bus));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask
  task automatic clr();
    bus.i_start = 0; bus.i_step = 1; bus.i_stall = 0; bus.i_halt = 0;
    bus.i_branch_taken = 0; bus.i_branch_pc = 0; bus.i_branch_offset = 0;
    bus.i_jump = 0; bus.i_jump_pc = 0; bus.i_instr_index = 0;
    bus.i_jr = 0; bus.i_jr_target = 0;
  endtask
  task automatic cyc(input string tag, input logic en, input logic fif, input logic fex,
                     input logic mis, input logic [31:0] nxt);
    #1;
    chk({tag, ".pc_en"}, 32'(bus.o_pc_en), 32'(en));
    chk({tag, ".flush_if_id"}, 32'(bus.o_flush_if_id), 32'(fif));
    chk({tag, ".flush_id_ex"}, 32'(bus.o_flush_id_ex), 32'(fex));
    chk({tag, ".misaligned"}, 32'(bus.o_misaligned), 32'(mis));
    q.push_back(nxt);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".pc"}, bus.o_pc, q.pop_front());
    clr();
  endtask
  task automatic status(input string tag, input logic run, input logic hlt);
    chk({tag, ".running"}, 32'(bus.o_running), 32'(run));
    chk({tag, ".halted"}, 32'(bus.o_halted), 32'(hlt));
  endtask
  initial begin
    clr();
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("reset.pc", bus.o_pc, 32'h0);
    status("reset", 0, 0);
    rst = 0;
    cyc("idle", 0, 0, 0, 0, 32'h0);
    bus.i_start = 1; bus.i_jump = 1; bus.i_instr_index = 26'h40;
    cyc("start", 0, 0, 0, 0, 32'h0);
    status("started", 1, 0);
    cyc("seq0", 1, 0, 0, 0, 32'h4);
    cyc("seq1", 1, 0, 0, 0, 32'h8);
    cyc("seq2", 1, 0, 0, 0, 32'hC);
    cyc("seq3", 1, 0, 0, 0, 32'h10);
    bus.i_branch_taken = 1; bus.i_branch_pc = 32'hC; bus.i_branch_offset = 16'hFFFE;
    cyc("branch_back", 1, 1, 1, 0, 32'h4);
    bus.i_jump = 1; bus.i_jump_pc = 32'h1000_0008; bus.i_instr_index = 26'h40;
    cyc("jump", 1, 1, 0, 0, 32'h1000_0100);
    for (int i = 0; i < 2; i++) begin
      bus.i_stall = 1; bus.i_jump = 1; bus.i_jump_pc = 32'h2000_0000; bus.i_instr_index = 26'h10;
      cyc("stall_jump", 0, 0, 0, 0, 32'h1000_0100);
    end
    bus.i_jump = 1; bus.i_jump_pc = 32'h2000_0000; bus.i_instr_index = 26'h10;
    cyc("jump_after_stall", 1, 1, 0, 0, 32'h2000_0040);
    bus.i_jr = 1; bus.i_jr_target = 32'h0000_0203; bus.i_jump = 1; bus.i_jump_pc = 32'h3000_0000;
    cyc("jr_over_jump", 1, 1, 0, 1, 32'h200);
    bus.i_branch_taken = 1; bus.i_branch_pc = 32'h200; bus.i_branch_offset = 16'h0004;
    bus.i_stall = 1; bus.i_jump = 1;
    cyc("branch_over_stall", 1, 1, 1, 0, 32'h210);
    bus.i_step = 0;
`ifdef PC_STEP_MODE_EN
    cyc("no_step_frozen", 0, 0, 0, 0, 32'h210);
    bus.i_step = 0; bus.i_jr = 1; bus.i_jr_target = 32'h4;
    cyc("no_step_jr_ignored", 0, 0, 0, 0, 32'h210);
    cyc("step_pulse", 1, 0, 0, 0, 32'h214);
`else
    cyc("step_ignored", 1, 0, 0, 0, 32'h214);
`endif
    bus.i_jr = 1; bus.i_jr_target = 32'hFFFF_FFFC;
    cyc("jr_aligned", 1, 1, 0, 0, 32'hFFFF_FFFC);
    cyc("wrap", 1, 0, 0, 0, 32'h0);
    bus.i_branch_taken = 1; bus.i_branch_pc = 32'h0; bus.i_branch_offset = 16'h0010; bus.i_halt = 1;
    cyc("branch_over_halt", 1, 1, 1, 0, 32'h40);
    status("after_branch_halt", 1, 0);
    bus.i_halt = 1; bus.i_stall = 1; bus.i_jump = 1;
    cyc("halt", 0, 0, 0, 0, 32'h40);
    status("halted", 0, 1);
    bus.i_start = 1; bus.i_branch_taken = 1; bus.i_branch_offset = 16'h0100; bus.i_jr = 1;
    cyc("halted_ignores", 0, 0, 0, 0, 32'h40);
    status("still_halted", 0, 1);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("reset_from_halt.pc", bus.o_pc, 32'h0);
    status("reset_from_halt", 0, 0);
    bus.i_start = 1;
    cyc("restart", 0, 0, 0, 0, 32'h0);
    cyc("rerun0", 1, 0, 0, 0, 32'h4);
    cyc("rerun1", 1, 0, 0, 0, 32'h8);
    rst = 1; bus.i_branch_taken = 1; bus.i_branch_pc = 32'h100; bus.i_jump = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    clr();
    chk("midrun_reset.pc", bus.o_pc, 32'h0);
    status("midrun_reset", 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
